// File: rtl/mac_pkg.sv
// Shared constants and types for the MAC pipeline and its downstream stream stages.
package mac_pkg;

  localparam int MAC_LATENCY = 5;
  localparam int SUM_W       = 24;
  localparam int ACC_W       = 32;

  typedef struct packed {
    logic valid;
    logic last;
  } mac_tag_t;

  typedef logic [ACC_W-1:0] acc_t;

endpackage

// File: rtl/mac_result_fifo.sv
// Synchronous result FIFO with occupancy count and a head that is read straight from storage flops.
module mac_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     push_drop,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             pop;
  logic             push_ok;

  // Stream handshake: a beat transfers on a rising edge where out_valid and out_ready
  // are both high. out_valid never drops and out_data never changes until that beat
  // transfers, and out_valid does not depend on out_ready.
  assign out_valid = (count != '0);
  assign full      = (count == FULL_CNT);
  assign pop       = out_valid & out_ready;
  assign push_ok   = push & (~full | pop);
  assign push_drop = push & full & ~pop;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      // Full with push and pop together: the slot being popped is the one overwritten.
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mac_result_collector.sv
// Tracks MAC launches through the fixed pipeline latency, accumulates sums into group
// results, and queues them for a valid/ready consumer with credit-based launch permission.
module mac_result_collector #(
  parameter int MAC_LATENCY = mac_pkg::MAC_LATENCY,
  parameter int SUM_W       = mac_pkg::SUM_W,
  parameter int ACC_W       = mac_pkg::ACC_W,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     launch_i,
  input  logic                     last_i,
  output logic                     launch_ready_o,
  input  logic [SUM_W-1:0]         mac_sum_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [ACC_W-1:0]         out_data_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic                     busy_o,
  output logic                     overflow_o
);

  import mac_pkg::*;

  localparam int IW = $clog2(MAC_LATENCY + 1);

  mac_tag_t         tags [MAC_LATENCY];
  mac_tag_t         exit_tag;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] sum_ext;
  logic [IW-1:0]    last_in_flight;
  logic             group_open;
  logic             push;
  logic             push_drop;
  logic             any_tag;

  assign exit_tag = tags[MAC_LATENCY-1];
  assign sum_ext  = {{(ACC_W - SUM_W){1'b0}}, mac_sum_i};
  assign acc_next = acc + sum_ext;
  assign push     = exit_tag.valid & exit_tag.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAC_LATENCY; i++) tags[i] <= '0;
    end else begin
      tags[0] <= '{valid: launch_i, last: launch_i & last_i};
      for (int i = 1; i < MAC_LATENCY; i++) tags[i] <= tags[i-1];
    end
  end

  // A closing tag clears the accumulator even when its result is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      group_open <= 1'b0;
    end else if (exit_tag.valid) begin
      acc        <= exit_tag.last ? '0 : acc_next;
      group_open <= ~exit_tag.last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_in_flight <= '0;
    end else begin
      case ({launch_i & last_i, push})
        2'b10:   last_in_flight <= last_in_flight + 1'b1;
        2'b01:   last_in_flight <= last_in_flight - 1'b1;
        default: last_in_flight <= last_in_flight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            overflow_o <= 1'b0;
    else if (push_drop) overflow_o <= 1'b1;
  end

  always_comb begin
    any_tag = 1'b0;
    for (int i = 0; i < MAC_LATENCY; i++) any_tag = any_tag | tags[i].valid;
  end

  // Every closing launch reserves a FIFO slot until its result is popped.
  assign launch_ready_o = (int'(fifo_count_o) + int'(last_in_flight)) < DEPTH;
  assign busy_o         = any_tag | group_open | (fifo_count_o != '0);

  mac_result_fifo #(
    .WIDTH (ACC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (acc_next),
    .push_drop (push_drop),
    .out_valid (out_valid_o),
    .out_ready (out_ready_i),
    .out_data  (out_data_o),
    .count     (fifo_count_o)
  );

endmodule

// File: tb/tb_mac_result_collector.sv
// Directed and randomized bench for mac_result_collector; the bench plays the MAC and
// predicts group results from launch order alone.
module tb_mac_result_collector;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        launch_i = 1'b0;
  logic        last_i = 1'b0;
  logic        launch_ready_o;
  logic [23:0] mac_sum_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_data_o;
  logic [2:0]  fifo_count_o;
  logic        busy_o;
  logic        overflow_o;

  always #5 clk = ~clk;

  mac_result_collector dut (
    .clk            (clk),
    .rst            (rst),
    .launch_i       (launch_i),
    .last_i         (last_i),
    .launch_ready_o (launch_ready_o),
    .mac_sum_i      (mac_sum_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_data_o     (out_data_o),
    .fifo_count_o   (fifo_count_o),
    .busy_o         (busy_o),
    .overflow_o     (overflow_o)
  );

  int          n_assert = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [23:0] sched_sum [8];
  bit          sched_vld [8];
  logic [W-1:0] grp = '0;
  bit          prev_hold = 1'b0;
  logic [W-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    grp = '0;
    prev_hold = 1'b0;
    for (int i = 0; i < 8; i++) sched_vld[i] = 1'b0;
  endtask

  // One clock: called just after a falling edge, returns just after the next one.
  task automatic step(input logic l, input logic lst, input logic [23:0] s, input logic rdy);
    logic [W-1:0] e;
    if (prev_hold) begin
      check("hold_valid", out_valid_o, 1);
      check("hold_data", out_data_o, prev_data);
    end
    launch_i    = l;
    last_i      = l & lst;
    out_ready_i = rdy;
    if (sched_vld[cyc % 8]) begin
      mac_sum_i = sched_sum[cyc % 8];
      sched_vld[cyc % 8] = 1'b0;
    end else begin
      mac_sum_i = 24'($urandom);
    end
    if (l) begin
      sched_sum[(cyc + 5) % 8] = s;
      sched_vld[(cyc + 5) % 8] = 1'b1;
      grp = grp + {8'h00, s};
      if (lst) begin
        exp_q.push_back(grp);
        grp = '0;
      end
    end
    if (out_valid_o && rdy) begin
      if (exp_q.size() == 0) check("pop_unexpected", out_valid_o, 0);
      else begin
        e = exp_q.pop_front();
        check("pop_data", out_data_o, e);
      end
    end
    prev_hold = out_valid_o && !rdy;
    prev_data = out_data_o;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'h0, rdy);
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < max_cyc) begin
      step(1'b0, 1'b0, 24'h0, 1'b1);
      n++;
    end
    check({tag, "_missing"}, 32'(exp_q.size()), 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_count"}, fifo_count_o, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, out_valid_o, 0);
    check({tag, "_data"}, out_data_o, 0);
    check({tag, "_count"}, fifo_count_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_ovf"}, overflow_o, 0);
    check({tag, "_lready"}, launch_ready_o, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int n;
    logic l, lst, rdy;

    for (int i = 0; i < 8; i++) sched_vld[i] = 1'b0;

    // Power-on reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    // Single group: launch at t, result visible at t+6
    step(1, 1, 24'd16, 0);
    idle(4, 0);
    check("single_t5_valid", out_valid_o, 0);
    check("single_t5_busy", busy_o, 1);
    idle(1, 0);
    check("single_t6_valid", out_valid_o, 1);
    check("single_t6_data", out_data_o, 16);
    check("single_t6_count", fifo_count_o, 1);
    step(0, 0, 0, 1);
    check("single_pop_count", fifo_count_o, 0);
    check("single_pop_busy", busy_o, 0);

    // Three-launch group closes on the third launch
    step(1, 0, 24'd10, 0);
    step(1, 0, 24'd20, 0);
    step(1, 1, 24'd30, 0);
    idle(4, 0);
    check("multi_t7_count", fifo_count_o, 0);
    idle(1, 0);
    check("multi_t8_valid", out_valid_o, 1);
    check("multi_t8_data", out_data_o, 60);
    check("multi_t8_count", fifo_count_o, 1);
    step(0, 0, 0, 1);
    check("multi_pop_count", fifo_count_o, 0);

    // Backpressure: four credits, then a forced fifth push meeting a pop on a full FIFO
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) check("bp_lready_before4", launch_ready_o, 1);
      step(1, 1, 24'(k), 0);
    end
    check("bp_lready_after4", launch_ready_o, 0);
    step(1, 1, 24'd5, 0);
    idle(4, 0);
    check("bp_full_count", fifo_count_o, 4);
    check("bp_full_head", out_data_o, 1);
    check("bp_full_lready", launch_ready_o, 0);
    step(0, 0, 0, 1);
    check("bp_pushpop_count", fifo_count_o, 4);
    check("bp_pushpop_head", out_data_o, 2);
    drain("bp_drain", 20);

    // Overflow: full FIFO, forced closing launch with sum 99 is dropped
    for (int k = 1; k <= 4; k++) step(1, 1, 24'(100 + k), 0);
    idle(6, 0);
    check("ovf_full_count", fifo_count_o, 4);
    step(1, 1, 24'd99, 0);
    void'(exp_q.pop_back());
    idle(4, 0);
    check("ovf_before", overflow_o, 0);
    idle(1, 0);
    check("ovf_set", overflow_o, 1);
    check("ovf_count", fifo_count_o, 4);
    check("ovf_head", out_data_o, 101);
    drain("ovf_drain", 20);
    check("ovf_sticky", overflow_o, 1);
    step(1, 1, 24'd7, 0);
    idle(6, 0);
    check("ovf_next_valid", out_valid_o, 1);
    check("ovf_next_acc_clear", out_data_o, 7);
    drain("ovf_next_drain", 20);

    // Reset mid-flight with a partial sum already accumulated
    step(1, 0, 24'd40, 0);
    idle(5, 0);
    step(1, 1, 24'd50, 0);
    idle(1, 0);
    rst = 1'b1;
    step(0, 0, 0, 0);
    rst = 1'b0;
    clear_model();
    check_reset_outputs("midrst");
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | out_valid_o;
      step(0, 0, 0, 0);
    end
    check("midrst_no_valid", seen, 0);
    step(1, 1, 24'd5, 1);
    drain("midrst_drain", 20);

    // Wrap: 257 launches of 0xFFFFFF
    for (int i = 0; i < 256; i++) step(1, 0, 24'hFFFFFF, 1);
    step(1, 1, 24'hFFFFFF, 1);
    n = 0;
    while (!out_valid_o && n < 10) begin
      step(0, 0, 0, 0);
      n++;
    end
    check("wrap_valid", out_valid_o, 1);
    check("wrap_data", out_data_o, 32'h00FFFEFF);
    drain("wrap_drain", 20);

    // Randomized traffic respecting credits, with random backpressure
    for (int i = 0; i < 400; i++) begin
      l   = 1'($urandom_range(0, 1));
      lst = ($urandom_range(0, 2) == 0) && (exp_q.size() < 4);
      rdy = ($urandom_range(0, 3) != 0);
      check("rand_lready", launch_ready_o, 32'(exp_q.size() < 4));
      check("rand_ovf", overflow_o, 0);
      step(l, lst, 24'($urandom), rdy);
    end
    step(1, 1, 24'($urandom), 1);
    drain("rand_drain", 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_result_collector.md
# mac_result_collector

Downstream companion of the 4x4 MAC pipeline: tracks each operand launch through the MAC's fixed 5-cycle latency, captures the matching `total_sum`, and accumulates consecutive sums into one group result (tiled dot products larger than 16 terms). Completed group results are buffered in a small FIFO and drained over a valid/ready stream to the next consumer. The block also issues credit-based launch permission, because the MAC itself cannot stall.

## Interface
- `MAC_LATENCY`, 5: cycles from the operand launch to a valid `total_sum`.
- `SUM_W`, 24: width of the MAC sum input.
- `ACC_W`, 32: accumulator and output width.
- `DEPTH`, 4: result FIFO entries (power of two, ≥2).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `launch_i`  in  1  operands presented to the MAC this cycle.
- `last_i`  in  1  qualifies `launch_i`: this launch closes the current group.
- `launch_ready_o`  out  1  a group-closing launch may be issued this cycle.
- `mac_sum_i`  in  SUM_W  MAC `total_sum`.
- `out_valid_o`  out  1  FIFO head valid.
- `out_ready_i`  in  1  consumer accepts the head.
- `out_data_o`  out  ACC_W  FIFO head (group result).
- `fifo_count_o`  out  $clog2(DEPTH)+1  occupied entries.
- `busy_o`  out  1  any tag in flight, accumulator non-zero-group open, or FIFO non-empty.
- `overflow_o`  out  1  sticky: a result was dropped.

## Operation
- **Tag pipeline:** MAC_LATENCY-deep shift register of {valid, last}. It is loaded with {`launch_i`, `launch_i & last_i`} every cycle.
- **Tag exit:** when a valid tag exits, `mac_sum_i` is sampled that cycle and zero-extended to ACC_W.
  - Non-last tag: acc <= acc + sum.
  - Last tag: push (acc + sum) into the FIFO, and acc <= 0.
- **Arithmetic:** accumulation wraps modulo 2^ACC_W. No saturation, no flag.
- **Credits:** `launch_ready_o` = (fifo_count + last-tags in flight) < DEPTH. Non-last launches are always permitted.
- **Protocol violation:** a last launch issued while `launch_ready_o` is low is a protocol violation. If its push finds the FIFO full with no same-cycle pop, the value is dropped, `overflow_o` is set, the FIFO is unchanged, and acc still clears.
- **FIFO push/pop:**
  - A pop occurs when `out_valid_o & out_ready_i`.
  - Simultaneous push and pop when full: both happen and the count stays at DEPTH.
  - Simultaneous push and pop when empty: the push is not visible until the next cycle, so no pop occurs.
- **Output stability:** `out_data_o` holds stable while `out_valid_o & !out_ready_i`.
- **Reset:**
  - All outputs are 0 except `launch_ready_o`, which is 1.
  - Tags, acc, FIFO pointers, count and `overflow_o` are cleared.
  - In-flight results are discarded. Reset mid-group leaves no partial sum.

## Timing
- Launch at cycle t → its sum is sampled at cycle t+MAC_LATENCY.
- Group result written at the end of t+5. `out_valid_o` is high from t+6 if the FIFO was empty (6-cycle launch-to-output latency).
- `launch_ready_o` is combinational from registered state only. It falls in the cycle after a last launch that consumes the final credit, and rises in the cycle after the pop that frees a slot.
- One launch per cycle sustained. With no backpressure, one group result per cycle for back-to-back single-launch groups.
- `overflow_o` rises the cycle after the dropped push and remains high until `rst`.

## Structure
- Shared package `mac_pkg`:
  - Constants `MAC_LATENCY`, `SUM_W`, `ACC_W`.
  - Typedef `mac_tag_t` (packed struct {logic valid; logic last;}).
  - Typedef `acc_t` (logic [ACC_W-1:0]).
- Sub-module `mac_result_fifo`: synchronous FIFO parameterised by width/depth, with count output and registered head. It is reused by other stream stages.
- Top-level: tag shift register, accumulator, credit counter (in-flight last tags), overflow flag.

## Test plan
- **Single group:** one last launch at t with `mac_sum_i`=16 at t+5 → `out_valid_o`=1 at t+6 with `out_data_o`=16; pop → count 0, `busy_o` 0.
- **Multi-launch group:** 3 back-to-back launches (last on the third), sums 10, 20, 30 → exactly one result, 60, at t+8.
- **Backpressure:** hold `out_ready_i`=0 and issue 4 single-launch groups (sums 1..4).
  - `launch_ready_o` low after the 4th launch; count reaches 4.
  - Pop while a 5th push arrives → count remains 4, order 1,2,3,4,5.
- **Overflow:** FIFO full with ready=0, force a last launch with sum 99 → `overflow_o`=1 from the next cycle; FIFO contents unchanged; acc is 0 for the next group.
- **Reset mid-flight:** launch with last at t, assert `rst` at t+2 for 1 cycle → no `out_valid_o` ever; all outputs at reset values.
- **Wrap:** 257 launches, last on the 257th, each sum 0xFFFFFF → result 0x00FFFEFF.
